kbus_cycle_sequencer: RTL

- Generates the Konami-2 CPU bus timing that feeds the bus-control/chip-select stage.
- From SYSCLK (24 MHz) it derives:
  - the 12 MHz clock-enable pair CK12_CE/NCK12_CE;
  - the E/Q quadrature levels CKE/CKQ and the CKQ_CE edge pulse;
  - the AS address strobe.
- It consumes DTAC from the bus-control stage and stretches the E-high phase until DTAC acknowledges.
- It pulses CPU_CE to advance the CPU core once per completed bus cycle.

---
 rtl/kbus_cycle_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/kbus_cycle_sequencer.sv
// Konami-2 CPU bus cycle sequencer: 12 MHz enables, E/Q quadrature, AS strobe and DTAC stretch.
// Define KBUS_WATCHDOG_EN to bound DTAC stretches with a WDOG_CYCLES watchdog that raises BUSERR.
module kbus_cycle_sequencer #(
   parameter int unsigned WDOG_CYCLES = 64
) (
   input  logic SYSCLK,
   input  logic nRESET,
   input  logic VMA,
   input  logic DTAC,
   output logic CK12_CE,
   output logic NCK12_CE,
   output logic CKE,
   output logic CKQ,
   output logic CKQ_CE,
   output logic AS,
   output logic WAIT,
   output logic CPU_CE,
   output logic BUSERR
);

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } ph_t;

   ph_t  r_ph;
   logic r_t;
   logic r_cke;
   logic r_ckq;
   logic r_ckq_ce;
   logic r_as;
   logic r_wait;
   logic r_cpu_ce;
   logic r_buserr;
   logic w_force;
   logic w_stretch;

`ifdef KBUS_WATCHDOG_EN
   logic [7:0] r_wdog;

   assign w_force = (r_wdog == 8'(WDOG_CYCLES));
`else
   logic w_unused_wdog;

   assign w_force       = 1'b0;
   assign w_unused_wdog = (WDOG_CYCLES == 0);
`endif

   // Only a real (AS low) cycle waits on DTAC; a watchdog expiry completes it regardless.
   assign w_stretch = ~r_as & DTAC & ~w_force;

   // NOTE: every register below is assigned with <= so all of them see the pre-edge values
   // of r_ph/r_as within one SYSCLK edge; blocking here would chain the decodes.
   always_ff @(posedge SYSCLK or negedge nRESET) begin
      if (!nRESET) begin
         r_t      <= 1'b0;
         r_ph     <= PH0;
         r_cke    <= 1'b0;
         r_ckq    <= 1'b0;
         r_ckq_ce <= 1'b0;
         r_as     <= 1'b1;
         r_wait   <= 1'b0;
         r_cpu_ce <= 1'b0;
         r_buserr <= 1'b0;
`ifdef KBUS_WATCHDOG_EN
         r_wdog   <= 8'd0;
`endif
      end else begin
         r_t      <= ~r_t;
         r_ckq_ce <= 1'b0;
         r_cpu_ce <= 1'b0;
         r_buserr <= 1'b0;
         if (r_t) begin
            unique case (r_ph)
               PH0: begin
                  r_ph     <= PH1;
                  r_ckq    <= 1'b1;
                  r_ckq_ce <= 1'b1;
                  r_as     <= ~VMA;
               end
               PH1: begin
                  r_ph  <= PH2;
                  r_cke <= 1'b1;
               end
               PH2: begin
                  r_ph  <= PH3;
                  r_ckq <= 1'b0;
               end
               PH3: begin
                  if (w_stretch) begin
                     r_wait <= 1'b1;
`ifdef KBUS_WATCHDOG_EN
                     r_wdog <= r_wdog + 8'd1;
`endif
                  end else begin
                     r_ph     <= PH0;
                     r_cke    <= 1'b0;
                     r_wait   <= 1'b0;
                     r_as     <= 1'b1;
                     r_cpu_ce <= 1'b1;
                     r_buserr <= w_force & ~r_as & DTAC;
`ifdef KBUS_WATCHDOG_EN
                     r_wdog   <= 8'd0;
`endif
                  end
               end
            endcase
         end
      end
   end

   assign CK12_CE  = r_t;
   assign NCK12_CE = ~r_t;
   assign CKE      = r_cke;
   assign CKQ      = r_ckq;
   assign CKQ_CE   = r_ckq_ce;
   assign AS       = r_as;
   assign WAIT     = r_wait;
   assign CPU_CE   = r_cpu_ce;
`ifdef KBUS_WATCHDOG_EN
   assign BUSERR   = r_buserr;
`else
   assign BUSERR   = 1'b0;
`endif

endmodule
